// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync/blank decode, frame_start.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif
`ifndef VGA_MERGE
`define VGA_MERGE(hc, vc, hs, vs, hb, vb, rgb) {hc, vc, hs, vs, hb, vb, rgb}
`endif

module vga_timing_gen #(
  parameter int H_ACTIVE     = 1024,
  parameter int H_SYNC_START = 1048,
  parameter int H_SYNC_END   = 1184,
  parameter int H_TOTAL      = 1344,
  parameter int V_ACTIVE     = 768,
  parameter int V_SYNC_START = 771,
  parameter int V_SYNC_END   = 777,
  parameter int V_TOTAL      = 806
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic [`VGA_BUS_SIZE-1:0] vga_out,
  output logic                     frame_start
);

  localparam logic [10:0] HA    = 11'(H_ACTIVE);
  localparam logic [10:0] HSS   = 11'(H_SYNC_START);
  localparam logic [10:0] HSE   = 11'(H_SYNC_END);
  localparam logic [10:0] HT_M1 = 11'(H_TOTAL - 1);
  localparam logic [10:0] VA    = 11'(V_ACTIVE);
  localparam logic [10:0] VSS   = 11'(V_SYNC_START);
  localparam logic [10:0] VSE   = 11'(V_SYNC_END);
  localparam logic [10:0] VT_M1 = 11'(V_TOTAL - 1);

  logic [10:0] h_q, h_d, v_q, v_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic        hblnk_q, hblnk_d, vblnk_q, vblnk_d;
  logic        fs_q, fs_d;
  logic [11:0] rgb;

  // Every registered field is decoded from the same next (h,v) so no field lags.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    hblnk_d = hblnk_q;
    vblnk_d = vblnk_q;
    fs_d    = fs_q;
    if (en) begin
      h_d = (h_q == HT_M1) ? 11'd0 : h_q + 11'd1;
      if (h_q == HT_M1)
        v_d = (v_q == VT_M1) ? 11'd0 : v_q + 11'd1;
      hs_d    = (h_d >= HSS) && (h_d < HSE);
      vs_d    = (v_d >= VSS) && (v_d < VSE);
      hblnk_d = (h_d >= HA);
      vblnk_d = (v_d >= VA);
      fs_d    = (h_d == 11'd0) && (v_d == 11'd0);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
      fs_q    <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      hblnk_q <= hblnk_d;
      vblnk_q <= vblnk_d;
      fs_q    <= fs_d;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  logic [11:0] rgb_q, rgb_d;
  logic [10:0] bar;

  always_comb begin
    rgb_d = rgb_q;
    bar   = h_d / BAR_W;
    if (en) begin
      rgb_d = 12'h000;
      if ((h_d < HA) && (v_d < VA)) begin
        case (bar)
          11'd0:   rgb_d = 12'hfff;
          11'd1:   rgb_d = 12'hff0;
          11'd2:   rgb_d = 12'h0ff;
          11'd3:   rgb_d = 12'h0f0;
          11'd4:   rgb_d = 12'hf0f;
          11'd5:   rgb_d = 12'hf00;
          11'd6:   rgb_d = 12'h00f;
          default: rgb_d = 12'h000;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) rgb_q <= 12'h000;
    else        rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`else
  assign rgb = 12'h000;
`endif

  assign vga_out     = `VGA_MERGE(h_q, v_q, hs_q, vs_q, hblnk_q, vblnk_q, rgb);
  assign frame_start = fs_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter H_SYNC_START, default 1048, first hcount with hs asserted.
REQ-003 SHALL have parameter H_SYNC_END, default 1184, first hcount after hs pulse.
REQ-004 SHALL have parameter H_TOTAL, default 1344, pixels per line including blanking.
REQ-005 SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 SHALL have parameter V_SYNC_START, default 771, first vcount with vs asserted.
REQ-007 SHALL have parameter V_SYNC_END, default 777, first vcount after vs pulse.
REQ-008 SHALL have parameter V_TOTAL, default 806, lines per frame.
REQ-009 SHALL have port pclk  input  1  pixel clock (65 MHz), single clock domain.
REQ-010 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-011 SHALL have port en  input  1  count enable; low freezes all counters and outputs.
REQ-012 SHALL have port vga_out  output  `VGA_BUS_SIZE  VGA bus packed with the standard VGA merge macro (hcount 11b, vcount 11b, hs, vs, hblnk, vblnk, rgb 12b).
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse marking pixel (0,0).

Function
REQ-014 SHALL increment hcount by 1 on every pclk rising edge with en=1.
REQ-015 SHALL wrap hcount from H_TOTAL-1 to 0 and, in that same edge, increment vcount.
REQ-016 SHALL wrap vcount from V_TOTAL-1 to 0 when hcount wraps on line V_TOTAL-1.
REQ-017 SHALL drive hblnk=1 iff hcount>=H_ACTIVE, and vblnk=1 iff vcount>=V_ACTIVE.
REQ-018 SHALL drive hs=1 iff H_SYNC_START<=hcount<H_SYNC_END, and vs=1 iff V_SYNC_START<=vcount<V_SYNC_END (positive logic on the bus; pad polarity is handled at top level).
REQ-019 SHALL register all outputs so that every bus field in a given cycle corresponds to the same (hcount,vcount) pair; no field may lag another.
REQ-020 SHALL assert frame_start for exactly one en-qualified cycle, when the registered output is (0,0).
REQ-021 SHALL drive rgb=12'h000 on the bus when VGA_TEST_PATTERN_EN is undefined.
REQ-022 SHALL, with en=0, hold every output at its current value, including frame_start (a held pulse stays high until en returns).
REQ-023 SHALL never produce hcount>=H_TOTAL or vcount>=V_TOTAL.

Reset
REQ-024 SHALL, while rst_n=0, force hcount=0, vcount=0, hs=0, vs=0, hblnk=0, vblnk=0, rgb=0, frame_start=1, independent of pclk.
REQ-025 SHALL, on the first en=1 edge after rst_n rises, output hcount=1, vcount=0, frame_start=0.
REQ-026 SHALL, on reset asserted mid-frame, restart the timing from (0,0) with no residual sync pulse.

Configuration
REQ-027 SHALL, with macro VGA_TEST_PATTERN_EN defined, drive rgb in the active area as 8 vertical colour bars, each H_ACTIVE/8 wide (white, yellow, cyan, green, magenta, red, blue, black), and rgb=0 in blanking.
REQ-028 SHALL, without VGA_TEST_PATTERN_EN, contain no pattern logic and drive rgb=0 everywhere.

Verification
REQ-029 SHALL verify: reset release, en=1, 1344 edges -> hcount returns to 0, vcount=1, hblnk high for exactly 320 cycles per line.
REQ-030 SHALL verify: run one full frame (1344*806=1,083,264 cycles) -> frame_start pulses exactly once; vs high for exactly 6*1344=8064 cycles.
REQ-031 SHALL verify: at hcount=1047 -> hs=0; at 1048..1183 -> hs=1; at 1184 -> hs=0.
REQ-032 SHALL verify: en=0 for 50 cycles at hcount=500, vcount=300 -> bus unchanged; en=1 -> next hcount=501.
REQ-033 SHALL verify: rst_n pulled low asynchronously at (700,400) between edges -> outputs zero immediately; after release, counting resumes from (1,0).
REQ-034 SHALL verify, with VGA_TEST_PATTERN_EN: hcount=0 -> rgb=12'hfff; hcount=128 -> rgb=12'hff0; hcount=1023 -> rgb=12'h000; vcount=768 -> rgb=12'h000.
